// File: rtl/atoi_parser_pkg.sv
// Shared definitions for the number-conversion block.
//   state_t  : conversion FSM states
//   CH_*     : ASCII codes recognised while scanning a token
package atoi_parser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    PARSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_LA    = 8'h61;
  localparam logic [7:0] CH_LF    = 8'h66;
  localparam logic [7:0] CH_UA    = 8'h41;
  localparam logic [7:0] CH_UF    = 8'h46;
  localparam logic [7:0] CH_MINUS = 8'h2D;

endpackage

// File: rtl/mb8_io.sv
// Byte-memory bus.
//   we : write enable
//   vi : write-data valid
//   ai : byte address
// Read data returns on a separate port one cycle after ai.
interface mb8_io #(
  parameter int ASZ = 17
);
  logic           we;
  logic           vi;
  logic [ASZ-1:0] ai;

  modport master (output we, output vi, output ai);
  modport slave  (input  we, input  vi, input  ai);
endinterface

// File: rtl/atoi_parser_digit.sv
// Combinational digit decoder.
//   ch    : ASCII byte
//   hex   : 1 accepts a-f / A-F as well as 0-9
//   valid : ch is a digit in the selected radix
//   val   : digit value 0..15
module digit_dec
  import atoi_parser_pkg::*;
#(
  parameter int MSZ = 8
) (
  input  logic [MSZ-1:0] ch,
  input  logic           hex,
  output logic           valid,
  output logic [3:0]     val
);

  always_comb begin
    valid = 1'b0;
    val   = 4'd0;
    if (ch >= CH_0 && ch <= CH_9) begin
      valid = 1'b1;
      val   = 4'(ch - CH_0);
    end else if (hex && ch >= CH_LA && ch <= CH_LF) begin
      valid = 1'b1;
      val   = 4'(ch - CH_LA + 8'd10);
    end else if (hex && ch >= CH_UA && ch <= CH_UF) begin
      valid = 1'b1;
      val   = 4'(ch - CH_UA + 8'd10);
    end
  end

endmodule

// File: rtl/atoi_parser.sv
// Signed decimal/hex string to integer converter.
//   clk, rst : clock, asynchronous active-low reset
//   en       : hold high for the whole conversion; low returns to idle
//   hex      : radix select, latched at start
//   tib      : address of first token character
//   ch       : memory read data for the address driven one cycle earlier
//   mb_if    : memory bus (read-only use: we=0, vi=0, ai=address)
//   bsy      : conversion in progress
//   vo       : result, valid when bsy falls, held until next start
module atoi_parser
  import atoi_parser_pkg::*;
#(
  parameter int ASZ = 17,
  parameter int DSZ = 32,
  parameter int MSZ = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           hex,
  input  logic [ASZ-1:0] tib,
  input  logic [MSZ-1:0] ch,
  mb8_io.master          mb_if,
  output logic           bsy,
  output logic [DSZ-1:0] vo
);

  state_t         state, state_nx;
  logic [ASZ-1:0] ai;
  logic [DSZ-1:0] acc, acc_sh, acc_nx;
  logic           neg, first, hex_r;
  logic           dig_ok, is_minus;
  logic [3:0]     dig;

  digit_dec #(.MSZ(MSZ)) u_dec (
    .ch    (ch),
    .hex   (hex_r),
    .valid (dig_ok),
    .val   (dig)
  );

  // Sign is only honoured as the very first byte; later it delimits.
  assign is_minus = first && (ch == CH_MINUS);
  assign acc_sh   = hex_r ? (acc << 4) : ((acc << 3) + (acc << 1));
  assign acc_nx   = acc_sh + DSZ'(dig);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = WAIT;
      WAIT:    state_nx = en ? PARSE : IDLE;
      PARSE:   if (!en) state_nx = IDLE;
               else if (!(is_minus || dig_ok)) state_nx = DONE;
      DONE:    if (!en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bsy         = (state == WAIT) || (state == PARSE);
    mb_if.we    = 1'b0;
    mb_if.vi    = 1'b0;
    mb_if.ai    = ai;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ai    <= '0;
      acc   <= '0;
      neg   <= 1'b0;
      first <= 1'b0;
      hex_r <= 1'b0;
      vo    <= '0;
    end else begin
      case (state)
        IDLE: if (en) begin
          ai    <= tib;
          acc   <= '0;
          neg   <= 1'b0;
          first <= 1'b1;
          hex_r <= hex;
        end
        WAIT: if (en) ai <= ai + 1'b1;
        PARSE: if (en) begin
          if (is_minus) begin
            neg   <= 1'b1;
            first <= 1'b0;
            ai    <= ai + 1'b1;
          end else if (dig_ok) begin
            acc   <= acc_nx;
            first <= 1'b0;
            ai    <= ai + 1'b1;
          end else begin
            // Delimiter: ai is left pointing one past it.
            vo <= neg ? (~acc + 1'b1) : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atoi_parser.sv
module tb_atoi_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        hex = 1'b0;
  logic [16:0] tib = '0;
  logic [7:0]  ch;
  logic        bsy;
  logic [31:0] vo;

  logic [7:0]  mem [0:131071];
  int          nerr = 0;
  int          nchk = 0;

  mb8_io #(.ASZ(17)) mb ();

  atoi_parser #(.ASZ(17), .DSZ(32), .MSZ(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .hex   (hex),
    .tib   (tib),
    .ch    (ch),
    .mb_if (mb),
    .bsy   (bsy),
    .vo    (vo)
  );

  always #5 clk = ~clk;

  // One-cycle read latency memory.
  always @(posedge clk) ch <= mem[mb.ai];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [16:0] a, input string s, input logic [7:0] d);
    for (int i = 0; i < s.len(); i++) mem[17'(a + i)] = s[i];
    mem[17'(a + s.len())]     = d;
    mem[17'(a + s.len() + 1)] = 8'h20;
  endtask

  function automatic int dval(input logic [7:0] c, input bit h);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (h && c >= "a" && c <= "f") return int'(c) - 97 + 10;
    if (h && c >= "A" && c <= "F") return int'(c) - 65 + 10;
    return -1;
  endfunction

  // Reference: scan the token in memory, result modulo 2^32.
  task automatic model(input logic [16:0] t, input bit h, output logic [31:0] v, output int n);
    longint unsigned acc = 0;
    bit neg = 0;
    int i = 0;
    if (mem[t] == "-") begin neg = 1; i = 1; end
    while (dval(mem[17'(t + i)], h) >= 0) begin
      acc = (acc * (h ? 16 : 10) + longint'(dval(mem[17'(t + i)], h))) % 64'h1_0000_0000;
      i++;
    end
    v = neg ? 32'(0 - acc) : 32'(acc);
    n = i;
  endtask

  // Start a conversion and wait for bsy to fall; cyc = cycles with bsy high.
  task automatic run(input logic [16:0] t, input bit h, output int cyc);
    tib = t; hex = h; en = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (bsy && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
    end
    chk("timeout", 64'(cyc < 200), 64'd1);
  endtask

  task automatic idle1();
    en = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, n;
    logic [31:0] ev, prev_vo;
    logic [16:0] t;
    string pool, tok;
    logic [7:0] dl [5];
    dl[0] = 8'h20; dl[1] = 8'h00; dl[2] = 8'h0D; dl[3] = 8'h67; dl[4] = 8'h2D;

    for (int i = 0; i < 131072; i++) mem[i] = 8'h20;

    #2;
    chk("rst_bsy", 64'(bsy), 0);
    chk("rst_vo", 64'(vo), 0);
    chk("rst_ai", 64'(mb.ai), 0);
    chk("rst_we", 64'(mb.we), 0);
    chk("rst_vi", 64'(mb.vi), 0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    load(17'h100, "123", 8'h20);
    run(17'h100, 1'b0, cyc);
    chk("dec_cyc", 64'(cyc), 5);
    chk("dec_vo", 64'(vo), 123);
    chk("dec_ai", 64'(mb.ai), 17'h104);
    idle1();

    load(17'h180, "-42", 8'h00);
    run(17'h180, 1'b0, cyc);
    chk("neg_vo", 64'(vo), 32'hFFFF_FFD6);
    chk("neg_ai", 64'(mb.ai), 17'h184);
    idle1();

    load(17'h1C0, "7fFf", 8'h20);
    run(17'h1C0, 1'b1, cyc);
    chk("hex_vo", 64'(vo), 32'h7FFF);
    chk("hex_ai", 64'(mb.ai), 17'h1C5);
    idle1();
    run(17'h1C0, 1'b0, cyc);
    chk("hexdec_vo", 64'(vo), 7);
    chk("hexdec_ai", 64'(mb.ai), 17'h1C2);
    idle1();

    load(17'h1E0, "4294967297", 8'h20);
    run(17'h1E0, 1'b0, cyc);
    chk("wrap_vo", 64'(vo), 1);
    idle1();

    load(17'h1F0, "", 8'h20);
    run(17'h1F0, 1'b0, cyc);
    chk("empty_vo", 64'(vo), 0);
    chk("empty_cyc", 64'(cyc), 2);
    chk("empty_ai", 64'(mb.ai), 17'h1F1);
    idle1();

    load(17'h1F8, "99", 8'h20);
    run(17'h1F8, 1'b0, cyc);
    idle1();
    load(17'h1F8, "-", 8'h20);
    run(17'h1F8, 1'b0, cyc);
    chk("lone_minus_vo", 64'(vo), 0);
    chk("lone_minus_ai", 64'(mb.ai), 17'h1FA);
    idle1();

    load(17'h1F8, "--5", 8'h20);
    run(17'h1F8, 1'b0, cyc);
    chk("dbl_minus_vo", 64'(vo), 0);
    chk("dbl_minus_ai", 64'(mb.ai), 17'h1FA);
    idle1();

    // Abort in PARSE: vo keeps the previous result.
    load(17'h1E0, "321", 8'h20);
    run(17'h1E0, 1'b0, cyc);
    idle1();
    prev_vo = 32'd321;
    load(17'h200, "98765", 8'h20);
    tib = 17'h200; hex = 1'b0; en = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("abort_pre_bsy", 64'(bsy), 1);
    en = 1'b0;
    @(posedge clk); #1;
    chk("abort_bsy", 64'(bsy), 0);
    chk("abort_vo", 64'(vo), 64'(prev_vo));
    @(posedge clk); #1;
    chk("abort_idle_bsy", 64'(bsy), 0);
    load(17'h240, "55", 8'h20);
    run(17'h240, 1'b0, cyc);
    chk("restart_vo", 64'(vo), 55);
    chk("restart_ai", 64'(mb.ai), 17'h243);
    idle1();

    // Asynchronous reset mid-parse.
    tib = 17'h200; en = 1'b1;
    repeat (2) @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst_bsy", 64'(bsy), 0);
    chk("arst_vo", 64'(vo), 0);
    chk("arst_ai", 64'(mb.ai), 0);
    en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Hold in DONE.
    load(17'h300, "77", 8'h0D);
    run(17'h300, 1'b0, cyc);
    chk("hold_vo0", 64'(vo), 77);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("hold_vo", 64'(vo), 77);
      chk("hold_ai", 64'(mb.ai), 17'h303);
      chk("hold_bsy", 64'(bsy), 0);
      chk("hold_we", 64'(mb.we), 0);
    end
    idle1();

    // Randomized tokens against the reference model.
    for (int it = 0; it < 40; it++) begin
      bit h;
      h = 1'($urandom_range(0, 1));
      pool = h ? "0123456789abcdefABCDEF" : "0123456789";
      tok = ($urandom_range(0, 2) == 0) ? "-" : "";
      n = $urandom_range(0, 11);
      for (int j = 0; j < n; j++) begin
        string c;
        c = " ";
        c[0] = pool[$urandom_range(0, pool.len() - 1)];
        tok = {tok, c};
      end
      t = 17'($urandom_range(16'h400, 17'h1FF00));
      load(t, tok, dl[$urandom_range(0, 4)]);
      model(t, h, ev, n);
      run(t, h, cyc);
      chk("rnd_vo", 64'(vo), 64'(ev));
      chk("rnd_ai", 64'(mb.ai), 64'(17'(t + n + 1)));
      chk("rnd_cyc", 64'(cyc), 64'(n + 2));
      idle1();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
